// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, BCD nibble width and elaboration-time helpers.
package bin2bcd_seq_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Combinational double-dabble cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] nib_i,
    output logic [BCD_W-1:0] nib_o
);

    // Inputs never exceed 9, so the sum stays within the nibble.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= BCD_W'(5)) begin
            nib_o = nib_i + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Inputs above 10^DIGITS-1 saturate to all 9s and raise o_overflow.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned DIGITS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [BIN_W-1:0]          i_bin_data,
    input  logic                      i_bin_valid_go,
    output logic                      o_busy,
    output logic [BCD_W*DIGITS-1:0]   o_bcd_data,
    output logic                      o_bcd_valid_go,
    output logic                      o_overflow
);

    localparam int unsigned     BCD_BITS = BCD_W * DIGITS;
    localparam int unsigned     CNT_W    = (clog2(BIN_W) > 0) ? clog2(BIN_W) : 1;
    localparam longint unsigned MAXV     = pow10(DIGITS) - 1;
    // Overflow is only reachable when the input range extends past MAXV.
    localparam bit              OVF_POSSIBLE =
        (BIN_W < 64) && (MAXV < ((64'd1 << BIN_W) - 64'd1));
    localparam logic [BIN_W-1:0] MAXV_T = OVF_POSSIBLE ? BIN_W'(MAXV) : {BIN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [BCD_BITS-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [BCD_BITS-1:0]  data_q, data_d;
    logic                 ovf_out_q, ovf_out_d;
    logic                 valid_q, valid_d;

    logic [BCD_BITS-1:0]  bcd_adj;
    logic [BCD_BITS-1:0]  bcd_shift;
    logic                 req_ovf;
    logic                 unused_adj_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[g*BCD_W +: BCD_W]),
            .nib_o (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // The top adjusted bit is always 0 for in-range values and falls off the shift.
    assign unused_adj_msb = bcd_adj[BCD_BITS-1];
    assign bcd_shift      = {bcd_adj[BCD_BITS-2:0], bin_q[BIN_W-1]};
    assign req_ovf        = OVF_POSSIBLE && (i_bin_data > MAXV_T);

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        data_d    = data_q;
        ovf_out_d = ovf_out_q;
        valid_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_bin_valid_go) begin
                    bin_d   = req_ovf ? MAXV_T : i_bin_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = req_ovf;
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    data_d    = bcd_shift;
                    ovf_out_d = ovf_q;
                    valid_d   = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            data_q    <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
            ovf_out_q <= ovf_out_d;
            valid_q   <= valid_d;
        end
    end

    assign o_busy         = (state_q == StShift);
    assign o_bcd_data     = data_q;
    assign o_bcd_valid_go = valid_q;
    assign o_overflow     = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomised self-checking bench for bin2bcd_seq (BIN_W=27, DIGITS=8).
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 27;
    localparam int unsigned DIGITS = 8;

    logic              clk;
    logic              rst;
    logic [BIN_W-1:0]  bin;
    logic              go;
    logic              busy;
    logic [31:0]       bcd;
    logic              valid;
    logic              ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_bin_data     (bin),
        .i_bin_valid_go (go),
        .o_busy         (busy),
        .o_bcd_data     (bcd),
        .o_bcd_valid_go (valid),
        .o_overflow     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) n_valid <= n_valid + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_bcd(input logic [BIN_W-1:0] v);
        int unsigned x;
        logic [31:0] r;
        x = (v > 27'd99_999_999) ? 99_999_999 : int'(v);
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called #1 after the edge that sampled the request; returns in the valid cycle.
    task automatic wait_done(input string tag, input logic [31:0] exp_bcd, input logic exp_ovf);
        int cyc;
        bit busy_ok;
        cyc = 0;
        busy_ok = (busy === 1'b1);
        while (valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (valid !== 1'b1 && busy !== 1'b1) busy_ok = 0;
        end
        check({tag, "/latency"}, 64'(cyc), 64'(BIN_W));
        check({tag, "/busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "/busy_end"}, 64'(busy), 64'd0);
        check({tag, "/data"}, 64'(bcd), 64'(exp_bcd));
        check({tag, "/ovf"}, 64'(ovf), 64'(exp_ovf));
    endtask

    task automatic convert(input string tag, input logic [BIN_W-1:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        bin = v;
        go  = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        wait_done(tag, exp_bcd, exp_ovf);
    endtask

    initial begin
        int base;
        logic [BIN_W-1:0] v;

        rst = 1'b1;
        go  = 1'b0;
        bin = '0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/data", 64'(bcd), 64'd0);
        check("rst/valid", 64'(valid), 64'd0);
        check("rst/ovf", 64'(ovf), 64'd0);
        rst = 1'b0;

        convert("known", 27'd12_345_678, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        check("known/pulse_width", 64'(valid), 64'd0);
        check("known/hold", 64'(bcd), 64'h1234_5678);

        convert("zero", 27'd0, 32'h0000_0000, 1'b0);
        convert("maxv", 27'd99_999_999, 32'h9999_9999, 1'b0);
        convert("maxv_p1", 27'd100_000_000, 32'h9999_9999, 1'b1);
        convert("all_ones", 27'h7FF_FFFF, 32'h9999_9999, 1'b1);
        @(posedge clk); #1;
        check("all_ones/ovf_hold", 64'(ovf), 64'd1);

        // Requests sampled at clocks 5 and 27 arrive while busy and must be dropped.
        @(posedge clk); #1;
        base = n_valid;
        bin = 27'd42;
        go  = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 27; n++) begin
            go  = (n == 5 || n == 27);
            bin = 27'd7;
            @(posedge clk); #1;
        end
        check("drop/valid", 64'(valid), 64'd1);
        check("drop/data", 64'(bcd), 64'h42);
        check("drop/ovf", 64'(ovf), 64'd0);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("drop/accept28", 64'(busy), 64'd1);
        wait_done("drop/second", 32'h0000_0007, 1'b0);
        @(posedge clk); #1;
        check("drop/pulses", 64'(n_valid - base), 64'd2);

        // Reset during SHIFT aborts; a request on the last reset edge is ignored.
        bin = 27'd555;
        go  = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bin = 27'd123;
        go  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        go  = 1'b0;
        base = n_valid;
        check("midrst/busy", 64'(busy), 64'd0);
        check("midrst/data", 64'(bcd), 64'd0);
        check("midrst/ovf", 64'(ovf), 64'd0);
        check("midrst/valid", 64'(valid), 64'd0);
        repeat (30) begin @(posedge clk); #1; end
        check("midrst/no_pulse", 64'(n_valid - base), 64'd0);
        check("midrst/idle", 64'(busy), 64'd0);
        convert("midrst/after", 27'd9876, 32'h0000_9876, 1'b0);

        // Back-to-back at the maximum rate: each request is issued in the valid cycle.
        for (int i = 0; i < 1000; i++) begin
            v = BIN_W'($urandom);
            convert("rand", v, ref_bcd(v), v > 27'd99_999_999);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
